// File: rtl/self_write_seq_pkg.sv
// Shared state encoding and CRC constants for the self-write sequencer.
// SELF_WRITE_SEQ_CRC_EN adds the CRC state to the encoding.
package self_write_seq_pkg;

   localparam logic [31:0] DEFAULT_SYNC_WORD = 32'hFAB0_FAB1;
   localparam logic [15:0] CRC_POLY          = 16'h1021;
   localparam logic [15:0] CRC_INIT          = 16'hFFFF;

   typedef enum logic [2:0] {
      HUNT   = 3'd0,
      LEN    = 3'd1,
      DATA   = 3'd2,
      GAP    = 3'd3,
`ifdef SELF_WRITE_SEQ_CRC_EN
      CRC    = 3'd4,
`endif
      FINISH = 3'd5
   } state_t;

   // One byte of CRC-16-CCITT, MSB first, no reflection.
   function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in,
                                              input logic [7:0]  data_byte);
      logic [15:0] c;
      c = crc_in ^ {data_byte, 8'h00};
      for (int i = 0; i < 8; i++) begin
         c = c[15] ? ((c << 1) ^ CRC_POLY) : (c << 1);
      end
      return c;
   endfunction

endpackage

// File: rtl/seq_crc16.sv
// Byte-serial CRC-16-CCITT accumulator; clear reloads the init value.
module seq_crc16
   import self_write_seq_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic        byte_en,
   input  logic [7:0]  data_byte,
   output logic [15:0] crc
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         crc <= CRC_INIT;
      end else if (clear) begin
         crc <= CRC_INIT;
      end else if (byte_en) begin
         crc <= crc16_byte(crc, data_byte);
      end
   end

endmodule

// File: rtl/self_write_sequencer.sv
// Hunts a sync word, then turns a length-prefixed byte stream into paced 32-bit
// config writes. Defining SELF_WRITE_SEQ_CRC_EN adds a CRC-16 trailer check.
module self_write_sequencer
   import self_write_seq_pkg::*;
#(
   parameter logic [31:0] SYNC_WORD      = DEFAULT_SYNC_WORD,
   parameter int          GAP_CYCLES     = 4,
   parameter int          TIMEOUT_CYCLES = 1000000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   output logic        in_ready,
   output logic        self_write_strobe,
   output logic [31:0] self_write_data,
   output logic        com_active,
   output logic        done,
   output logic        error,
   output logic [2:0]  dbg_state
);

   localparam logic [15:0] GAP_LAST     = 16'(GAP_CYCLES - 1);
   localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

   state_t      state, state_n;
   logic [31:0] sreg, sreg_n;
   logic [31:0] wdata_n;
   logic [31:0] idle, idle_n;
   logic [15:0] words_left, words_n;
   logic [15:0] gcnt, gcnt_n;
   logic [1:0]  bcnt, bcnt_n;
   logic        strobe_n, error_n;
   logic        accept, word_done, in_payload;
   logic [31:0] shifted;

   // Handshake: a byte moves on a rising edge where in_valid && in_ready;
   // in_ready depends on state only, never on in_valid.
   assign in_ready   = (state != GAP) && (state != FINISH);
   assign com_active = (state != HUNT) && (state != FINISH);
   assign done       = (state == FINISH);
   assign dbg_state  = state;
   assign accept     = in_valid && in_ready;
   assign shifted    = {sreg[23:0], in_data};
   assign word_done  = in_payload && accept && (bcnt == 2'd3);

`ifdef SELF_WRITE_SEQ_CRC_EN
   logic        crc_clear, crc_en;
   logic [15:0] crc;

   assign in_payload = (state == LEN) || (state == DATA) || (state == CRC);

   seq_crc16 u_crc (
      .clk       (clk),
      .reset     (reset),
      .clear     (crc_clear),
      .byte_en   (crc_en),
      .data_byte (in_data),
      .crc       (crc)
   );
`else
   assign in_payload = (state == LEN) || (state == DATA);
`endif

   always_comb begin
      state_n  = state;
      sreg_n   = sreg;
      bcnt_n   = bcnt;
      words_n  = words_left;
      gcnt_n   = gcnt;
      idle_n   = '0;
      strobe_n = 1'b0;
      wdata_n  = self_write_data;
      error_n  = error;
`ifdef SELF_WRITE_SEQ_CRC_EN
      crc_clear = 1'b0;
      crc_en    = 1'b0;
`endif
      if (accept) begin
         sreg_n = shifted;
      end
      // A consumed word clears the shifter so stale bytes never form a false sync.
      if (word_done) begin
         sreg_n = '0;
      end

      if (in_payload) begin
         if (accept) begin
            bcnt_n = bcnt + 2'd1;
         end else if (idle == TIMEOUT_LAST) begin
            error_n = 1'b1;
            state_n = HUNT;
            sreg_n  = '0;
            bcnt_n  = '0;
         end else begin
            idle_n = idle + 32'd1;
         end
      end

      case (state)
         HUNT: begin
            bcnt_n = '0;
            if (accept && (shifted == SYNC_WORD)) begin
               state_n = LEN;
               error_n = 1'b0;
               sreg_n  = '0;
`ifdef SELF_WRITE_SEQ_CRC_EN
               crc_clear = 1'b1;
`endif
            end
         end
         LEN: begin
            if (word_done) begin
               if (shifted[15:0] == 16'd0) begin
                  error_n = 1'b1;
                  state_n = HUNT;
               end else begin
                  words_n = shifted[15:0];
                  state_n = DATA;
               end
            end
         end
         DATA: begin
`ifdef SELF_WRITE_SEQ_CRC_EN
            crc_en = accept;
`endif
            if (word_done) begin
               strobe_n = 1'b1;
               wdata_n  = shifted;
               words_n  = words_left - 16'd1;
               gcnt_n   = '0;
               state_n  = GAP;
            end
         end
         GAP: begin
            if (gcnt == GAP_LAST) begin
               if (words_left != 16'd0) begin
                  state_n = DATA;
               end else begin
`ifdef SELF_WRITE_SEQ_CRC_EN
                  state_n = CRC;
`else
                  state_n = FINISH;
`endif
               end
            end else begin
               gcnt_n = gcnt + 16'd1;
            end
         end
`ifdef SELF_WRITE_SEQ_CRC_EN
         CRC: begin
            if (word_done) begin
               if (shifted[15:0] == crc) begin
                  state_n = FINISH;
               end else begin
                  error_n = 1'b1;
                  state_n = HUNT;
               end
            end
         end
`endif
         FINISH:  state_n = HUNT;
         default: state_n = HUNT;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state             <= HUNT;
         sreg              <= '0;
         bcnt              <= '0;
         words_left        <= '0;
         gcnt              <= '0;
         idle              <= '0;
         self_write_strobe <= 1'b0;
         self_write_data   <= '0;
         error             <= 1'b0;
      end else begin
         state             <= state_n;
         sreg              <= sreg_n;
         bcnt              <= bcnt_n;
         words_left        <= words_n;
         gcnt              <= gcnt_n;
         idle              <= idle_n;
         self_write_strobe <= strobe_n;
         self_write_data   <= wdata_n;
         error             <= error_n;
      end
   end

endmodule

// File: tb/tb_self_write_sequencer.sv
// Bench for self_write_sequencer: randomized packets against a byte-stream parser model.
// Define SELF_WRITE_SEQ_CRC_EN to exercise the CRC trailer build.
module tb_self_write_sequencer;

   localparam int          GAP  = 4;
   localparam int          TMO  = 16;
   localparam logic [31:0] SYNC = 32'hFAB0_FAB1;

   logic        clk, reset, in_valid, in_ready;
   logic [7:0]  in_data;
   logic        self_write_strobe, com_active, done, error;
   logic [31:0] self_write_data;
   logic [2:0]  dbg_state;

   int checks, failures, cyc, last_strobe, done_cnt, stall_cnt, exp_done;
   logic        exp_err;
   logic [31:0] got_q[$];
   logic [31:0] exp_q[$];
   logic [7:0]  tx_q[$];

   self_write_sequencer #(
      .SYNC_WORD      (SYNC),
      .GAP_CYCLES     (GAP),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .in_valid          (in_valid),
      .in_data           (in_data),
      .in_ready          (in_ready),
      .self_write_strobe (self_write_strobe),
      .self_write_data   (self_write_data),
      .com_active        (com_active),
      .done              (done),
      .error             (error),
      .dbg_state         (dbg_state)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // monitor: collects strobes and done pulses, checks strobe pacing
   initial begin
      cyc = 0;
      last_strobe = -1000;
   end

   always @(negedge clk) begin
      cyc++;
      if (self_write_strobe === 1'b1) begin
         checks++;
         if (cyc - last_strobe < GAP) begin
            failures++;
            $display("FAIL strobe_spacing: got %0d cycles, required >= %0d", cyc - last_strobe, GAP);
         end
         last_strobe = cyc;
         got_q.push_back(self_write_data);
      end
      if (done === 1'b1) done_cnt++;
   end

   // reference model pieces
   function automatic logic [15:0] crc_byte(input logic [15:0] c_in, input logic [7:0] b);
      logic [15:0] c;
      logic        fb;
      c = c_in;
      for (int i = 7; i >= 0; i--) begin
         fb = c[15] ^ b[i];
         c  = {c[14:0], 1'b0};
         if (fb) c = c ^ 16'h1021;
      end
      return c;
   endfunction

   function automatic void model_parse();
      logic [31:0] w;
      logic [15:0] c;
      int          i, n;
      exp_q.delete();
      exp_done = 0;
      exp_err  = 1'b0;
      w = '0;
      i = 0;
      while (i < tx_q.size() && w != SYNC) begin
         w = {w[23:0], tx_q[i]};
         i++;
      end
      if (w != SYNC || i + 4 > tx_q.size()) return;
      n = int'({tx_q[i+2], tx_q[i+3]});
      i += 4;
      if (n == 0) begin
         exp_err = 1'b1;
         return;
      end
      c = 16'hFFFF;
      for (int k = 0; k < n; k++) begin
         if (i + 4 > tx_q.size()) return;
         exp_q.push_back({tx_q[i], tx_q[i+1], tx_q[i+2], tx_q[i+3]});
         for (int j = 0; j < 4; j++) c = crc_byte(c, tx_q[i+j]);
         i += 4;
      end
`ifdef SELF_WRITE_SEQ_CRC_EN
      if (i + 4 > tx_q.size()) return;
      if ({tx_q[i+2], tx_q[i+3]} == c) exp_done = 1;
      else exp_err = 1'b1;
`else
      exp_done = 1;
`endif
   endfunction

   // stimulus builders and drivers
   task automatic push_word(input logic [31:0] w);
      for (int s = 3; s >= 0; s--) tx_q.push_back(w[s*8 +: 8]);
   endtask

   task automatic add_trailer(input int first, input logic bad);
      logic [15:0] c;
      c = 16'hFFFF;
      for (int i = first; i < tx_q.size(); i++) c = crc_byte(c, tx_q[i]);
      push_word({16'h0, c ^ {15'h0, bad}});
   endtask

   task automatic build_packet(input int noise, input int n);
      tx_q.delete();
      repeat (noise) tx_q.push_back(8'($urandom_range(0, 255)));
      push_word(SYNC);
      push_word(32'(n));
      for (int k = 0; k < n; k++) push_word($urandom);
`ifdef SELF_WRITE_SEQ_CRC_EN
      add_trailer(noise + 8, 1'b0);
`endif
   endtask

   task automatic do_reset();
      reset    = 1'b1;
      in_valid = 1'b0;
      in_data  = '0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      got_q.delete();
      done_cnt  = 0;
      stall_cnt = 0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int waits;
      in_valid = 1'b1;
      in_data  = b;
      waits    = 0;
      @(negedge clk);
      while (in_ready !== 1'b1) begin
         waits++;
         stall_cnt++;
         if (waits > 200) begin
            checks++;
            failures++;
            $display("FAIL ready_wait: in_ready=%b after %0d cycles, required 1", in_ready, waits);
            break;
         end
         @(negedge clk);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send_range(input int first, input int last, input logic gaps);
      for (int i = first; i < last; i++) begin
         if (gaps && $urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
         end
         send_byte(tx_q[i]);
      end
      in_valid = 1'b0;
   endtask

   task automatic settle();
      repeat (GAP + 6) @(posedge clk);
      #1;
   endtask

   // scenarios
   task automatic test_reset();
      do_reset();
      @(negedge clk);
      checks += 6;
      if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b, required 1", in_ready); end
      if (self_write_strobe !== 1'b0) begin failures++; $display("FAIL reset_strobe: got %b, required 0", self_write_strobe); end
      if (self_write_data !== 32'h0) begin failures++; $display("FAIL reset_data: got %h, required 0", self_write_data); end
      if (com_active !== 1'b0) begin failures++; $display("FAIL reset_com_active: got %b, required 0", com_active); end
      if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b, required 0", done); end
      if (error !== 1'b0) begin failures++; $display("FAIL reset_error: got %b, required 0", error); end
   endtask

   task automatic test_fixed_packet();
      do_reset();
      tx_q.delete();
      push_word(SYNC);
      push_word(32'h0000_0002);
      push_word(32'h1122_3344);
      push_word(32'h5566_7788);
`ifdef SELF_WRITE_SEQ_CRC_EN
      add_trailer(8, 1'b0);
`endif
      model_parse();
      send_range(0, tx_q.size(), 1'b0);
      settle();
      checks++;
      if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL fixed_count: got %0d strobes, required %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL fixed_word%0d: got %h, required %h", i, got_q[i], exp_q[i]); end
      end
      checks += 4;
      if (done_cnt != exp_done) begin failures++; $display("FAIL fixed_done: got %0d pulses, required %0d", done_cnt, exp_done); end
      if (error !== exp_err) begin failures++; $display("FAIL fixed_error: got %b, required %b", error, exp_err); end
      if (self_write_data !== 32'h5566_7788) begin failures++; $display("FAIL fixed_data_hold: got %h, required 55667788", self_write_data); end
      if (com_active !== 1'b0) begin failures++; $display("FAIL fixed_com_active: got %b, required 0", com_active); end
   endtask

   task automatic test_noise_sync();
      do_reset();
      tx_q.delete();
      tx_q.push_back(8'h00);
      tx_q.push_back(8'hFA);
      push_word(SYNC);
      push_word(32'h0000_0002);
      push_word(32'h1122_3344);
      push_word(32'h5566_7788);
`ifdef SELF_WRITE_SEQ_CRC_EN
      add_trailer(10, 1'b0);
`endif
      model_parse();
      send_range(0, 5, 1'b0);
      checks++;
      if (com_active !== 1'b0) begin failures++; $display("FAIL noise_early_sync: com_active=%b after 5 bytes, required 0", com_active); end
      send_range(5, 6, 1'b0);
      checks++;
      if (com_active !== 1'b1) begin failures++; $display("FAIL noise_sync_offset2: com_active=%b after 6 bytes, required 1", com_active); end
      send_range(6, tx_q.size(), 1'b0);
      settle();
      checks++;
      if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL noise_count: got %0d strobes, required %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL noise_word%0d: got %h, required %h", i, got_q[i], exp_q[i]); end
      end
      checks++;
      if (done_cnt != exp_done) begin failures++; $display("FAIL noise_done: got %0d pulses, required %0d", done_cnt, exp_done); end
   endtask

   task automatic test_random_packets();
      for (int t = 0; t < 6; t++) begin
         do_reset();
         build_packet($urandom_range(0, 3), $urandom_range(1, 4));
         model_parse();
         send_range(0, tx_q.size(), 1'b1);
         settle();
         checks++;
         if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL rand%0d_count: got %0d strobes, required %0d", t, got_q.size(), exp_q.size()); end
         for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL rand%0d_word%0d: got %h, required %h", t, i, got_q[i], exp_q[i]); end
         end
         checks += 2;
         if (done_cnt != exp_done) begin failures++; $display("FAIL rand%0d_done: got %0d pulses, required %0d", t, done_cnt, exp_done); end
         if (error !== exp_err) begin failures++; $display("FAIL rand%0d_error: got %b, required %b", t, error, exp_err); end
      end
   endtask

   task automatic test_back_to_back();
      int exp_stall;
      do_reset();
      build_packet(0, 3);
      model_parse();
      send_range(0, tx_q.size(), 1'b0);
      settle();
`ifdef SELF_WRITE_SEQ_CRC_EN
      exp_stall = 3 * GAP;
`else
      exp_stall = 2 * GAP;
`endif
      checks += 3;
      if (stall_cnt != exp_stall) begin failures++; $display("FAIL b2b_stalls: got %0d stall cycles, required %0d", stall_cnt, exp_stall); end
      if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL b2b_count: got %0d strobes, required %0d", got_q.size(), exp_q.size()); end
      if (done_cnt != exp_done) begin failures++; $display("FAIL b2b_done: got %0d pulses, required %0d", done_cnt, exp_done); end
   endtask

   task automatic test_zero_len();
      do_reset();
      tx_q.delete();
      push_word(SYNC);
      push_word(32'h0000_0000);
      send_range(0, tx_q.size(), 1'b0);
      settle();
      checks += 4;
      if (error !== 1'b1) begin failures++; $display("FAIL zero_len_error: got %b, required 1", error); end
      if (com_active !== 1'b0) begin failures++; $display("FAIL zero_len_com_active: got %b, required 0", com_active); end
      if (got_q.size() != 0) begin failures++; $display("FAIL zero_len_strobe: got %0d strobes, required 0", got_q.size()); end
      if (done_cnt != 0) begin failures++; $display("FAIL zero_len_done: got %0d pulses, required 0", done_cnt); end
   endtask

   task automatic test_timeout();
      do_reset();
      build_packet(0, 1);
      send_range(0, 10, 1'b0);
      repeat (TMO - 1) @(posedge clk);
      #1;
      checks += 2;
      if (error !== 1'b0) begin failures++; $display("FAIL timeout_early: error=%b at cycle %0d, required 0", error, TMO - 1); end
      if (com_active !== 1'b1) begin failures++; $display("FAIL timeout_early_active: com_active=%b, required 1", com_active); end
      @(posedge clk);
      #1;
      checks += 2;
      if (error !== 1'b1) begin failures++; $display("FAIL timeout_error: error=%b at cycle %0d, required 1", error, TMO); end
      if (com_active !== 1'b0) begin failures++; $display("FAIL timeout_com_active: got %b, required 0", com_active); end
      settle();
      checks++;
      if (got_q.size() != 0) begin failures++; $display("FAIL timeout_strobe: got %0d strobes, required 0", got_q.size()); end
      build_packet(0, 1);
      model_parse();
      send_range(0, 4, 1'b0);
      checks++;
      if (error !== 1'b0) begin failures++; $display("FAIL timeout_error_clear: got %b after sync, required 0", error); end
      send_range(4, tx_q.size(), 1'b0);
      settle();
      checks += 2;
      if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin failures++; $display("FAIL timeout_recover_word: got %0d strobes, required 1 of %h", got_q.size(), exp_q[0]); end
      if (done_cnt != exp_done) begin failures++; $display("FAIL timeout_recover_done: got %0d pulses, required %0d", done_cnt, exp_done); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      build_packet(0, 1);
      send_range(0, tx_q.size(), 1'b0);
      settle();
      got_q.delete();
      done_cnt = 0;
      build_packet(0, 1);
      send_range(0, 11, 1'b0);
      in_valid = 1'b1;
      in_data  = tx_q[11];
      reset    = 1'b1;
      @(negedge clk);
      checks += 6;
      if (in_ready !== 1'b1) begin failures++; $display("FAIL mid_reset_in_ready: got %b, required 1", in_ready); end
      if (self_write_strobe !== 1'b0) begin failures++; $display("FAIL mid_reset_strobe: got %b, required 0", self_write_strobe); end
      if (self_write_data !== 32'h0) begin failures++; $display("FAIL mid_reset_data: got %h, required 0", self_write_data); end
      if (com_active !== 1'b0) begin failures++; $display("FAIL mid_reset_com_active: got %b, required 0", com_active); end
      if (done !== 1'b0) begin failures++; $display("FAIL mid_reset_done: got %b, required 0", done); end
      if (error !== 1'b0) begin failures++; $display("FAIL mid_reset_error: got %b, required 0", error); end
      @(posedge clk);
      #1;
      reset    = 1'b0;
      in_valid = 1'b0;
      settle();
      checks += 2;
      if (got_q.size() != 0) begin failures++; $display("FAIL mid_reset_no_strobe: got %0d strobes, required 0", got_q.size()); end
      if (done_cnt != 0) begin failures++; $display("FAIL mid_reset_no_done: got %0d pulses, required 0", done_cnt); end
   endtask

`ifdef SELF_WRITE_SEQ_CRC_EN
   task automatic test_crc_trailer();
      for (int bad = 0; bad < 2; bad++) begin
         do_reset();
         tx_q.delete();
         push_word(SYNC);
         push_word(32'h0000_0001);
         push_word(32'h3132_3334);
         add_trailer(8, bad[0]);
         model_parse();
         send_range(0, tx_q.size(), 1'b0);
         settle();
         checks += 3;
         if (done_cnt != exp_done) begin failures++; $display("FAIL crc%0d_done: got %0d pulses, required %0d", bad, done_cnt, exp_done); end
         if (error !== exp_err) begin failures++; $display("FAIL crc%0d_error: got %b, required %b", bad, error, exp_err); end
         if (got_q.size() != 1 || got_q[0] !== 32'h3132_3334) begin failures++; $display("FAIL crc%0d_word: got %0d strobes, required 1 of 31323334", bad, got_q.size()); end
      end
   endtask
`endif

   initial begin
      checks   = 0;
      failures = 0;
      reset    = 1'b1;
      in_valid = 1'b0;
      in_data  = '0;
      test_reset();
      test_fixed_packet();
      test_noise_sync();
      test_random_packets();
      test_back_to_back();
      test_zero_len();
      test_timeout();
      test_reset_mid();
`ifdef SELF_WRITE_SEQ_CRC_EN
      test_crc_trailer();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/self_write_sequencer.md
SELF_WRITE_SEQUENCER -- requirements
Module: self_write_sequencer

Interface
REQ-001 Parameter SYNC_WORD, 32'hFAB0_FAB1: packet header word.
REQ-002 Parameter GAP_CYCLES, 4: cycles (>=1) that in_ready is held low starting at each strobe cycle.
REQ-003 Parameter TIMEOUT_CYCLES, 1000000: idle cycles inside a packet before abort.
REQ-004 Port clk  input  1: single clock; all logic on rising edge.
REQ-005 Port reset  input  1: asynchronous, active-high reset.
REQ-006 Port in_valid  input  1: byte source valid.
REQ-007 Port in_data  input  8: byte source data.
REQ-008 Port in_ready  output  1: byte accepted when in_valid && in_ready.
REQ-009 Port self_write_strobe  output  1: one-cycle config write pulse to the fabric.
REQ-010 Port self_write_data  output  32: config word; valid with the strobe.
REQ-011 Port com_active  output  1: packet in progress.
REQ-012 Port done  output  1: one-cycle pulse on successful packet end.
REQ-013 Port error  output  1: sticky abort/format/CRC error flag.

Function
REQ-014 Accepted bytes SHALL shift MSB-first into a 32-bit word register; every 4th accepted byte in LEN/DATA/CRC completes a word.
REQ-015 FSM states SHALL be HUNT, LEN, DATA, GAP, CRC, FINISH.
REQ-016 HUNT: after each accepted byte the sliding 32-bit register SHALL be compared with SYNC_WORD; match -> LEN, byte count cleared, error cleared, com_active set.
REQ-017 LEN: completed word bits [15:0] = N; N==0 -> error=1, HUNT; otherwise DATA.
REQ-018 DATA: the cycle after the 4th byte is accepted, self_write_strobe SHALL be 1 for exactly one cycle with self_write_data = that word; state -> GAP.
REQ-019 self_write_data SHALL hold its value until the next strobe.
REQ-020 GAP: in_ready low for GAP_CYCLES cycles counted from the strobe cycle; then DATA if words remain, else CRC (macro defined) or FINISH.
REQ-021 in_ready SHALL be 1 in HUNT, LEN, DATA, CRC and 0 in GAP, FINISH.
REQ-022 FINISH: done=1 for one cycle, com_active cleared, -> HUNT.
REQ-023 In LEN/DATA/CRC, TIMEOUT_CYCLES consecutive cycles without an accepted byte -> error=1, com_active=0, partial word discarded, no strobe, -> HUNT.
REQ-024 Bytes arriving back-to-back (in_valid constantly 1) SHALL be accepted one per cycle whenever in_ready=1.

Reset
REQ-025 Reset SHALL force state HUNT, in_ready=1, self_write_strobe=0, self_write_data=0, com_active=0, done=0, error=0, all counters and CRC cleared.
REQ-026 Reset mid-packet SHALL abort immediately with no further strobe.

Configuration
REQ-027 Macro SELF_WRITE_SEQ_CRC_EN defined: CRC-16-CCITT (poly 0x1021, init 0xFFFF) over all DATA bytes in order; after the last GAP a 4-byte trailer word in state CRC; trailer [15:0] match -> FINISH, mismatch -> error=1, no done, HUNT.
REQ-028 Macro undefined: no CRC logic, no CRC state, no trailer; last GAP -> FINISH.

Structure
REQ-029 Package self_write_seq_pkg SHALL hold the state enum, default SYNC_WORD, CRC poly/init constants.
REQ-030 Sub-module seq_crc16 SHALL implement the byte-serial CRC (clear, byte_en, byte, crc out), instantiated only under SELF_WRITE_SEQ_CRC_EN.

Verification
REQ-031 Bytes FA B0 FA B1, 00 00 00 02, 11 22 33 44, 55 66 77 88 (no CRC build) -> strobes with 0x11223344 then 0x55667788, strobes >= GAP_CYCLES apart, done pulse, error=0.
REQ-032 Noise 00 FA FA B0 FA B1 then valid packet -> sync found at byte offset 2, normal strobes.
REQ-033 Length word 00 00 00 00 after sync -> error=1, no strobe, com_active=0, done never asserted.
REQ-034 In_valid dropped after 2 data bytes for TIMEOUT_CYCLES (set 16) -> error=1 at cycle 16, no strobe, next sync clears error.
REQ-035 CRC build, one data word 0x31323334 with correct trailer -> done; trailer wrong in bit 0 -> error=1, no done.
REQ-036 Reset asserted one cycle before an expected strobe -> strobe never appears, all outputs at reset values.
